// File: rtl/pipe_result_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_result_packer                                           |
// | Description : Packs the upstream 1-bit q stream into WORD_W-bit words with |
// |               a popcount, delivered over a valid/ready handshake.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_result_packer #(
  parameter int WORD_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         q_in,
  input  logic                         sample_valid_in,
  input  logic                         clear_in,
  input  logic                         word_ready_in,
  output logic [WORD_W-1:0]            word_out,
  output logic [$clog2(WORD_W+1)-1:0]  ones_out,
  output logic                         word_valid_out,
  output logic                         overflow_out
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int POP_W = $clog2(WORD_W+1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  logic [LATENCY-1:0] r_vld_dly;
  logic [WORD_W-2:0]  r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [POP_W-1:0]   r_acc;
  state_t             r_state;

  logic               w_vld_d;
  logic               w_fill;
  logic               w_done;
  logic [WORD_W-1:0]  w_full_word;
  logic [POP_W-1:0]   w_pop;

  // Upstream has no valid of its own; replay sample_valid_in LATENCY cycles late.
  generate
    if (LATENCY == 1) begin : g_lat_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_vld_dly <= '0;
        else if (clear_in) r_vld_dly <= '0;
        else               r_vld_dly <= sample_valid_in;
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_vld_dly <= '0;
        else if (clear_in) r_vld_dly <= '0;
        else               r_vld_dly <= {r_vld_dly[LATENCY-2:0], sample_valid_in};
      end
    end
  endgenerate

  assign w_vld_d     = r_vld_dly[LATENCY-1];
  assign w_fill      = w_vld_d & ~clear_in;
  assign w_done      = w_fill & (r_cnt == CNT_W'(WORD_W-1));
  assign w_full_word = {r_shreg, q_in};
  assign w_pop       = r_acc + POP_W'(q_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (clear_in) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_done) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (w_fill) begin
      r_shreg <= w_full_word[WORD_W-2:0];
      r_cnt   <= r_cnt + CNT_W'(1);
      r_acc   <= w_pop;
    end
  end

  // Output holding register: a completion while a word waits unaccepted is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_EMPTY;
      word_valid_out <= 1'b0;
      word_out       <= '0;
      ones_out       <= '0;
      overflow_out   <= 1'b0;
    end else begin
      if (clear_in) overflow_out <= 1'b0;
      case (r_state)
        S_EMPTY: begin
          if (w_done) begin
            word_out       <= w_full_word;
            ones_out       <= w_pop;
            word_valid_out <= 1'b1;
            r_state        <= S_FULL;
          end
        end
        S_FULL: begin
          if (word_ready_in) begin
            if (w_done) begin
              word_out <= w_full_word;
              ones_out <= w_pop;
            end else begin
              word_valid_out <= 1'b0;
              r_state        <= S_EMPTY;
            end
          end else if (w_done) begin
            overflow_out <= 1'b1;
          end
        end
        default: begin
          word_valid_out <= 1'b0;
          r_state        <= S_EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_result_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_result_packer                                        |
// | Description : Self-checking bench for pipe_result_packer (8-bit, lat 3).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pipe_result_packer;

  localparam int W   = 8;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         q_in;
  logic         sample_valid_in;
  logic         clear_in;
  logic         word_ready_in;
  logic [W-1:0] word_out;
  logic [3:0]   ones_out;
  logic         word_valid_out;
  logic         overflow_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: samples in flight, bits of the partial word, output slot.
  bit           pend_sv[$];
  bit           pend_q[$];
  bit           fill_bits[$];
  bit           m_valid;
  bit           m_ovf;
  logic [W-1:0] m_word;
  int           m_ones;
  logic [W-1:0] got[$];
  logic [W-1:0] exp_words[$];

  always #5 clk = ~clk;

  pipe_result_packer #(.WORD_W(W), .LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .q_in            (q_in),
    .sample_valid_in (sample_valid_in),
    .clear_in        (clear_in),
    .word_ready_in   (word_ready_in),
    .word_out        (word_out),
    .ones_out        (ones_out),
    .word_valid_out  (word_valid_out),
    .overflow_out    (overflow_out)
  );

  task automatic model_reset();
    pend_sv.delete();
    pend_q.delete();
    for (int i = 0; i < LAT; i++) begin
      pend_sv.push_back(1'b0);
      pend_q.push_back(1'b0);
    end
    fill_bits.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_word  = '0;
    m_ones  = 0;
  endtask

  // One clock: sv/qv describe a new upstream sample; its q appears LAT cycles later.
  task automatic step(input bit sv, input bit qv, input bit rdy, input bit clr);
    bit           a_sv;
    bit           a_q;
    bit           comp;
    logic [W-1:0] nw;
    a_sv = pend_sv.pop_front();
    a_q  = pend_q.pop_front();
    pend_sv.push_back(sv);
    pend_q.push_back(qv);
    sample_valid_in = sv;
    q_in            = a_sv ? a_q : 1'($urandom);
    word_ready_in   = rdy;
    clear_in        = clr;
    if (word_valid_out && rdy) got.push_back(word_out);
    if (m_valid && rdy) exp_words.push_back(m_word);
    @(posedge clk);
    comp = 1'b0;
    nw   = '0;
    if (clr) begin
      fill_bits.delete();
      m_ovf = 1'b0;
      foreach (pend_sv[i]) pend_sv[i] = 1'b0;
    end else if (a_sv) begin
      fill_bits.push_back(a_q);
      if (fill_bits.size() == W) begin
        comp = 1'b1;
        foreach (fill_bits[i]) nw = {nw[W-2:0], fill_bits[i]};
        fill_bits.delete();
      end
    end
    if (!m_valid) begin
      if (comp) begin
        m_valid = 1'b1;
        m_word  = nw;
        m_ones  = $countones(nw);
      end
    end else if (rdy) begin
      if (comp) begin
        m_word = nw;
        m_ones = $countones(nw);
      end else begin
        m_valid = 1'b0;
      end
    end else if (comp) begin
      m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_valid_in = 1'b0;
    q_in = 1'b0;
    clear_in = 1'b0;
    word_ready_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (word_out !== 8'h00) begin n_fail++; $display("FAIL reset_word: got %h want 00", word_out); end
    n_tests++; if (ones_out !== 4'd0) begin n_fail++; $display("FAIL reset_ones: got %0d want 0", ones_out); end
    n_tests++; if (word_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", word_valid_out); end
    n_tests++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_out); end
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    pat = 8'hB1;
    for (int i = 0; i < 8; i++) step(1'b1, pat[7-i], 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_valid_out !== 1'b0) begin n_fail++; $display("FAIL pattern_early_valid: got %b want 0", word_valid_out); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_valid_out !== 1'b1) begin n_fail++; $display("FAIL pattern_valid: got %b want 1", word_valid_out); end
    n_tests++; if (word_out !== 8'hB1) begin n_fail++; $display("FAIL pattern_word: got %h want b1", word_out); end
    n_tests++; if (ones_out !== 4'd4) begin n_fail++; $display("FAIL pattern_ones: got %0d want 4", ones_out); end
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_valid_out !== 1'b1 || word_out !== 8'hB1) begin n_fail++; $display("FAIL pattern_hold: got v=%b %h want v=1 b1", word_valid_out, word_out); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (word_valid_out !== 1'b0) begin n_fail++; $display("FAIL pattern_accept: got %b want 0", word_valid_out); end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'($urandom), 1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_valid_out !== 1'b1 || word_out !== 8'hFF) begin n_fail++; $display("FAIL gaps_word: got v=%b %h want v=1 ff", word_valid_out, word_out); end
    n_tests++; if (ones_out !== 4'd8) begin n_fail++; $display("FAIL gaps_ones: got %0d want 8", ones_out); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (word_valid_out !== 1'b0) begin n_fail++; $display("FAIL gaps_accept: got %b want 0", word_valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    bits = 16'h0FF0;
    got.delete();
    exp_words.delete();
    for (int i = 0; i < 16; i++) step(1'b1, bits[15-i], 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++; if (got.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d words want 2", got.size()); end
    else begin
      n_tests++; if (got[0] !== 8'h0F) begin n_fail++; $display("FAIL b2b_word0: got %h want 0f", got[0]); end
      n_tests++; if (got[1] !== 8'hF0) begin n_fail++; $display("FAIL b2b_word1: got %h want f0", got[1]); end
    end
    n_tests++; if (overflow_out !== 1'b0 || word_valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_final: got ovf=%b v=%b want 0 0", overflow_out, word_valid_out); end
  endtask

  task automatic test_overflow();
    logic [15:0] bits;
    bits = 16'hA55A;
    for (int i = 0; i < 16; i++) step(1'b1, bits[15-i], 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_out !== 8'hA5 || ones_out !== 4'd4) begin n_fail++; $display("FAIL ovf_held: got %h/%0d want a5/4", word_out, ones_out); end
    n_tests++; if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow_out); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++; if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow_out); end
    n_tests++; if (word_valid_out !== 1'b1 || word_out !== 8'hA5) begin n_fail++; $display("FAIL ovf_pending: got v=%b %h want v=1 a5", word_valid_out, word_out); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    logic [7:0] pat;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pat = 8'h3C;
    for (int i = 0; i < 8; i++) step(1'b1, pat[7-i], 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_valid_out !== 1'b1 || word_out !== 8'h3C) begin n_fail++; $display("FAIL clear_partial: got v=%b %h want v=1 3c", word_valid_out, word_out); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    pat = 8'($urandom);
    for (int i = 0; i < 8; i++) step(1'b1, pat[7-i], 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_valid_out !== 1'b0 || overflow_out !== 1'b0) begin n_fail++; $display("FAIL clear_on_done: got v=%b ovf=%b want 0 0", word_valid_out, overflow_out); end
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) step(1'b1, pat[7-i], 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_out !== 8'h5A) begin n_fail++; $display("FAIL clear_fresh: got %h want 5a", word_out); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat;
    pat = 8'hC3;
    for (int i = 0; i < 8; i++) step(1'b1, pat[7-i], 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_out !== 8'hC3) begin n_fail++; $display("FAIL rstmid_pre: got %h want c3", word_out); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (word_valid_out !== 1'b0 || word_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_async: got v=%b %h want v=0 00", word_valid_out, word_out); end
    n_tests++; if (ones_out !== 4'd0 || overflow_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_zero: got ones=%0d ovf=%b want 0 0", ones_out, overflow_out); end
    sample_valid_in = 1'b1;
    q_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_valid_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_leak: got %b want 0", word_valid_out); end
    pat = 8'h96;
    for (int i = 0; i < 8; i++) step(1'b1, pat[7-i], 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++; if (word_valid_out !== 1'b1 || word_out !== 8'h96) begin n_fail++; $display("FAIL rstmid_fresh: got v=%b %h want v=1 96", word_valid_out, word_out); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    got.delete();
    exp_words.delete();
    for (int c = 0; c < 500; c++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0));
      n_tests++; if (word_valid_out !== m_valid) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, word_valid_out, m_valid); end
      n_tests++; if (overflow_out !== m_ovf) begin n_fail++; $display("FAIL rand_ovf c%0d: got %b want %b", c, overflow_out, m_ovf); end
      n_tests++; if (word_out !== m_word) begin n_fail++; $display("FAIL rand_word c%0d: got %h want %h", c, word_out, m_word); end
      n_tests++; if (ones_out !== 4'(m_ones)) begin n_fail++; $display("FAIL rand_ones c%0d: got %0d want %0d", c, ones_out, m_ones); end
    end
    n_tests++; if (got.size() != exp_words.size()) begin n_fail++; $display("FAIL rand_xfer_count: got %0d want %0d", got.size(), exp_words.size()); end
    else begin
      foreach (got[i]) begin
        n_tests++; if (got[i] !== exp_words[i]) begin n_fail++; $display("FAIL rand_xfer%0d: got %h want %h", i, got[i], exp_words[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_gaps();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
